// File: rtl/wb_pkg.sv
// Shared types and sizes for the write-back stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: wb_entry_t (one pending register-file write), pointer/count widths,
//           and the scalar lane-masking helper used on the write path.
package wb_pkg;

   localparam int REG_SIZE    = 16;
   localparam int VECTOR_SIZE = 4;
   localparam int SEL_BITS    = 2;
   localparam int FIFO_DEPTH  = 4;   // power of two, >= 2

   localparam int DATA_W   = REG_SIZE * VECTOR_SIZE;
   localparam int WB_PTR_W = $clog2(FIFO_DEPTH);
   localparam int WB_CNT_W = WB_PTR_W + 1;   // must hold FIFO_DEPTH itself

   typedef struct packed {
      logic                isScalar;
      logic [SEL_BITS-1:0] dest;
      logic [DATA_W-1:0]   data;
   } wb_entry_t;

   // Scalar writes keep lane 0 (the low REG_SIZE bits) and zero the rest;
   // vector writes pass every lane through.
   function automatic logic [DATA_W-1:0] lane_mask(input wb_entry_t e);
      logic [DATA_W-1:0] r;
      r = e.data;
      if (e.isScalar) begin
         r = {{(DATA_W-REG_SIZE){1'b0}}, e.data[REG_SIZE-1:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for ALU results waiting for a free register-file write slot.
// Latency: a pushed entry becomes the head one cycle after the push edge (head is read combinationally).
// Backpressure: none internally; the caller must not push when count_o == FIFO_DEPTH or pop when empty.
// Ports: clk, reset (async, active-high), push_i/entry_i (tail write),
//        pop_i (advance head), head_o (oldest entry), count_o (occupancy).
module wb_fifo
   import wb_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                push_i,
   input  wb_entry_t           entry_i,
   input  logic                pop_i,
   output wb_entry_t           head_o,
   output logic [WB_CNT_W-1:0] count_o
);

   wb_entry_t             mem_q [FIFO_DEPTH];
   logic [WB_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [WB_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [WB_CNT_W-1:0]   count_q,  count_d;

   // Pointers wrap naturally because the depth is a power of two; full vs
   // empty is decided by the count, never by pointer equality.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;   // idle, or push+pop leaves occupancy unchanged
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through the count.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= entry_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: merges memory and ALU results into one register-file write per cycle.
// Latency: 1 cycle for memory and bypassed ALU results; buffered ALU results add their FIFO wait.
// Backpressure: memory is never stalled; ALU is throttled by aluReady (low while the buffer is full).
// Ports: clk/reset; ALU producer (aluValid/aluReady/aluIsScalar/aluDest/aluData);
//        memory producer (memValid/memIsScalar/memDest/memData);
//        register-file write port (regWrEnSc/regWrEnVec/regToWrite/dataIn); pendingCount.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int regSize    = REG_SIZE,
   parameter int vectorSize = VECTOR_SIZE,
   parameter int selBits    = SEL_BITS,
   parameter int fifoDepth  = FIFO_DEPTH
)(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            aluValid,
   output logic                            aluReady,
   input  logic                            aluIsScalar,
   input  logic [selBits-1:0]              aluDest,
   input  logic [vectorSize*regSize-1:0]   aluData,
   input  logic                            memValid,
   input  logic                            memIsScalar,
   input  logic [selBits-1:0]              memDest,
   input  logic [vectorSize*regSize-1:0]   memData,
   output logic                            regWrEnSc,
   output logic                            regWrEnVec,
   output logic [selBits-1:0]              regToWrite,
   output logic [vectorSize*regSize-1:0]   dataIn,
   output logic [$clog2(fifoDepth):0]      pendingCount
);

   wb_entry_t             alu_e, mem_e, head_e, sel_e;
   logic [WB_CNT_W-1:0]   count;
   logic                  alu_acc, fifo_empty, push, pop, wr;

   logic                  wr_sc_q,  wr_sc_d;
   logic                  wr_vec_q, wr_vec_d;
   logic [SEL_BITS-1:0]   dest_q,   dest_d;
   logic [DATA_W-1:0]     data_q,   data_d;

   assign alu_e = '{isScalar: aluIsScalar, dest: aluDest, data: aluData};
   assign mem_e = '{isScalar: memIsScalar, dest: memDest, data: memData};

   // Ready looks only at the registered count, so a same-cycle pop does not
   // open a slot; this keeps aluReady free of any path from memValid.
   assign aluReady   = (count != WB_CNT_W'(fifoDepth));
   assign alu_acc    = aluValid && aluReady;
   assign fifo_empty = (count == '0);

   // Priority: memory, then oldest buffered ALU result, then bypass. Any
   // accepted ALU result that is not bypassed goes to the tail, which keeps
   // ALU writes in acceptance order.
   always_comb begin
      sel_e = '0;
      wr    = 1'b0;
      pop   = 1'b0;
      push  = 1'b0;
      if (memValid) begin
         sel_e = mem_e;
         wr    = 1'b1;
         push  = alu_acc;
      end else if (!fifo_empty) begin
         sel_e = head_e;
         wr    = 1'b1;
         pop   = 1'b1;
         push  = alu_acc;
      end else if (alu_acc) begin
         sel_e = alu_e;
         wr    = 1'b1;
      end
   end

   wb_fifo u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .entry_i (alu_e),
      .pop_i   (pop),
      .head_o  (head_e),
      .count_o (count)
   );

   // sel_e is all-zero on a no-write cycle, so dest and data fall to 0 there.
   always_comb begin
      wr_sc_d  = wr &  sel_e.isScalar;
      wr_vec_d = wr & ~sel_e.isScalar;
      dest_d   = sel_e.dest;
      data_d   = lane_mask(sel_e);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_sc_q  <= 1'b0;
         wr_vec_q <= 1'b0;
         dest_q   <= '0;
         data_q   <= '0;
      end else begin
         wr_sc_q  <= wr_sc_d;
         wr_vec_q <= wr_vec_d;
         dest_q   <= dest_d;
         data_q   <= data_d;
      end
   end

   assign regWrEnSc    = wr_sc_q;
   assign regWrEnVec   = wr_vec_q;
   assign regToWrite   = dest_q;
   assign dataIn       = data_q;
   assign pendingCount = count;

endmodule
